i2c_bus_resolver: RTL and testbench

Parametrised open-drain I2C bus resolver and monitor for N on-chip agents plus one external pin pair. It wired-ANDs every agent's SCL/SDA release request with the external lines, then synchronises and glitch-filters the result. From the filtered lines it reports START, STOP and bus-busy, per-agent arbitration loss, and SCL stuck-low timeout. It sits between the I2C master/slave core instances and the pad ring, and is also used as the bus model in the bench top.

---
 rtl/i2c_bus_resolver.sv | 176 +++++++++++++++++
 tb/tb_i2c_bus_resolver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_resolver.sv
// i2c_bus_resolver: wired-AND open-drain I2C bus resolver with synchroniser, glitch filter,
// START/STOP/busy tracking, per-agent arbitration-loss flags and SCL stuck-low timeout.
`default_nettype none

module i2c_bus_resolver #(
  parameter int N_AGENTS  = 2,
  parameter int FILT_LEN  = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [N_AGENTS-1:0]  scl_oe_i,
  input  logic [N_AGENTS-1:0]  sda_oe_i,
  input  logic                 ext_scl_i,
  input  logic                 ext_sda_i,
  output logic                 scl_pad_oe_o,
  output logic                 sda_pad_oe_o,
  output logic                 scl_f_o,
  output logic                 sda_f_o,
  output logic                 start_o,
  output logic                 stop_o,
  output logic                 busy_o,
  output logic [N_AGENTS-1:0]  arb_lost_o,
  input  logic [TIMEOUT_W-1:0] timeout_limit_i,
  output logic                 timeout_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0]     FILT_LAST = CNT_W'(FILT_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TCNT_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] TCNT_MAX  = {TIMEOUT_W{1'b1}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [1:0] raw;
  logic [1:0] filt;

  assign scl_pad_oe_o = &scl_oe_i;
  assign sda_pad_oe_o = &sda_oe_i;
  assign raw = {sda_pad_oe_o & ext_sda_i, scl_pad_oe_o & ext_scl_i};

  // Index 0 carries SCL, index 1 carries SDA.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_line
      logic             s1;
      logic             s2;
      logic             f;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
          s1  <= 1'b1;
          s2  <= 1'b1;
          f   <= 1'b1;
          cnt <= '0;
        end else begin
          s1 <= raw[g];
          s2 <= s1;
          if (s2 == f) begin
            cnt <= '0;
          end else if (cnt == FILT_LAST) begin
            f   <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign filt[g] = f;
    end
  endgenerate

  logic scl_f;
  logic sda_f;
  logic scl_d;
  logic sda_d;

  assign scl_f   = filt[0];
  assign sda_f   = filt[1];
  assign scl_f_o = scl_f;
  assign sda_f_o = sda_f;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // SCL must be stable high across both samples, so simultaneous edges give no event.
  logic start_det;
  logic stop_det;
  logic scl_rise;

  assign start_det = scl_d & scl_f &  sda_d & ~sda_f;
  assign stop_det  = scl_d & scl_f & ~sda_d &  sda_f;
  assign scl_rise  = scl_f & ~scl_d;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       busy;

  assign busy = (state == ST_BUSY);

  logic [TIMEOUT_W-1:0] tcnt;
  logic                 tripped;
  logic                 tmo_en;
  logic                 fire;

  assign tmo_en = busy & ~scl_f & (timeout_limit_i != '0) & ~tripped;
  assign fire   = tmo_en & (tcnt == (timeout_limit_i - TCNT_ONE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_det) state_nxt = ST_BUSY;
      ST_BUSY: if (stop_det || fire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= ST_IDLE;
      start_o   <= 1'b0;
      stop_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_o   <= start_det;
      stop_o    <= stop_det;
      timeout_o <= fire;
    end
  end

  assign busy_o = busy;

  // Counter holds once tripped and saturates rather than wrapping.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tcnt    <= '0;
      tripped <= 1'b0;
    end else if (scl_f) begin
      tcnt    <= '0;
      tripped <= 1'b0;
    end else begin
      if (fire) begin
        tripped <= 1'b1;
      end else if (tmo_en && (tcnt != TCNT_MAX)) begin
        tcnt <= tcnt + TCNT_ONE;
      end
    end
  end

  logic [N_AGENTS-1:0] arb_set;
  logic                arb_clr;

  assign arb_set = (busy && scl_rise && !sda_f) ? sda_oe_i : '0;
  assign arb_clr = start_det | stop_det | fire;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      arb_lost_o <= '0;
    end else begin
      arb_lost_o <= arb_set | (arb_clr ? '0 : arb_lost_o);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_resolver.sv
// Directed self-checking bench for i2c_bus_resolver (N_AGENTS=2, FILT_LEN=3, TIMEOUT_W=16).
`default_nettype none

module tb_i2c_bus_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  scl_oe;
  logic [1:0]  sda_oe;
  logic        ext_scl;
  logic        ext_sda;
  logic        scl_pad_oe;
  logic        sda_pad_oe;
  logic        scl_f;
  logic        sda_f;
  logic        start_p;
  logic        stop_p;
  logic        busy;
  logic [1:0]  arb_lost;
  logic [15:0] tlimit;
  logic        timeout_p;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_stop = 0;
  int n_tmo = 0;

  i2c_bus_resolver #(.N_AGENTS(2), .FILT_LEN(3), .TIMEOUT_W(16)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst_n),
    .scl_oe_i        (scl_oe),
    .sda_oe_i        (sda_oe),
    .ext_scl_i       (ext_scl),
    .ext_sda_i       (ext_sda),
    .scl_pad_oe_o    (scl_pad_oe),
    .sda_pad_oe_o    (sda_pad_oe),
    .scl_f_o         (scl_f),
    .sda_f_o         (sda_f),
    .start_o         (start_p),
    .stop_o          (stop_p),
    .busy_o          (busy),
    .arb_lost_o      (arb_lost),
    .timeout_limit_i (tlimit),
    .timeout_o       (timeout_p)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_p)   n_start++;
    if (stop_p)    n_stop++;
    if (timeout_p) n_tmo++;
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; scl_oe = 2'b11; sda_oe = 2'b11; ext_scl = 1'b1; ext_sda = 1'b1; tlimit = 16'd0;
    ticks(3);
    checks++; if (scl_f !== 1'b1)     begin errors++; $display("FAIL reset_scl_f got %b exp 1", scl_f); end
    checks++; if (sda_f !== 1'b1)     begin errors++; $display("FAIL reset_sda_f got %b exp 1", sda_f); end
    checks++; if (start_p !== 1'b0 || stop_p !== 1'b0 || timeout_p !== 1'b0)
      begin errors++; $display("FAIL reset_pulses got %b%b%b exp 000", start_p, stop_p, timeout_p); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (arb_lost !== 2'b00) begin errors++; $display("FAIL reset_arb got %b exp 00", arb_lost); end
    scl_oe = 2'b10; #1;
    checks++; if (scl_pad_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_pad_oe got %b exp 0", scl_pad_oe); end
    scl_oe = 2'b11; sda_oe = 2'b01; #1;
    checks++; if (sda_pad_oe !== 1'b0 || scl_pad_oe !== 1'b1)
      begin errors++; $display("FAIL reset_pad_oe got scl %b sda %b exp 1 0", scl_pad_oe, sda_pad_oe); end
    sda_oe = 2'b11;
    ticks(1);
    rst_n = 1'b1;
    ticks(8);
  endtask

  task automatic test_start_stop;
    int s0, p0;
    s0 = n_start; p0 = n_stop;
    sda_oe = 2'b01;
    ticks(4);
    checks++; if (sda_f !== 1'b1) begin errors++; $display("FAIL ss_sda_lat4 got %b exp 1", sda_f); end
    ticks(1);
    checks++; if (sda_f !== 1'b0) begin errors++; $display("FAIL ss_sda_lat5 got %b exp 0", sda_f); end
    ticks(1);
    checks++; if (start_p !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL ss_start got start %b busy %b exp 1 1", start_p, busy); end
    ticks(1);
    checks++; if (start_p !== 1'b0) begin errors++; $display("FAIL ss_start_width got %b exp 0", start_p); end
    ticks(3);
    sda_oe = 2'b11;
    ticks(5);
    checks++; if (sda_f !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL ss_sda_rise got sda %b busy %b exp 1 1", sda_f, busy); end
    ticks(1);
    checks++; if (stop_p !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL ss_stop got stop %b busy %b exp 1 0", stop_p, busy); end
    ticks(3);
    checks++; if (n_start - s0 != 1 || n_stop - p0 != 1)
      begin errors++; $display("FAIL ss_counts got start %0d stop %0d exp 1 1", n_start - s0, n_stop - p0); end
  endtask

  task automatic test_glitch;
    int lows, s0, p0;
    s0 = n_start; p0 = n_stop;
    lows = 0;
    ext_scl = 1'b0;
    ticks(2);
    ext_scl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ticks(1);
      if (scl_f === 1'b0) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL glitch2_low_cycles got %0d exp 0", lows); end
    lows = 0;
    ext_scl = 1'b0;
    ticks(3);
    ext_scl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ticks(1);
      if (scl_f === 1'b0) lows++;
    end
    checks++; if (lows != 3) begin errors++; $display("FAIL glitch3_low_cycles got %0d exp 3", lows); end
    checks++; if (n_start != s0 || n_stop != p0 || busy !== 1'b0)
      begin errors++; $display("FAIL glitch_events got start %0d stop %0d busy %b exp 0 0 0", n_start - s0, n_stop - p0, busy); end
  endtask

  task automatic test_arbitration;
    tlimit = 16'd0;
    sda_oe = 2'b01;
    ticks(8);
    scl_oe = 2'b10;
    ticks(8);
    checks++; if (busy !== 1'b1 || arb_lost !== 2'b00)
      begin errors++; $display("FAIL arb_pre got busy %b arb %b exp 1 00", busy, arb_lost); end
    scl_oe = 2'b11;
    ticks(8);
    checks++; if (arb_lost !== 2'b01) begin errors++; $display("FAIL arb_set got %b exp 01", arb_lost); end
    sda_oe = 2'b11;
    ticks(8);
    checks++; if (arb_lost !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL arb_clear_on_stop got arb %b busy %b exp 00 0", arb_lost, busy); end
  endtask

  task automatic test_timeout;
    int t0;
    tlimit = 16'd100;
    t0 = n_tmo;
    sda_oe = 2'b10;
    ticks(8);
    scl_oe = 2'b10;
    ticks(104);
    checks++; if (timeout_p !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL tmo_early got tmo %b busy %b exp 0 1", timeout_p, busy); end
    ticks(1);
    checks++; if (timeout_p !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL tmo_pulse got tmo %b busy %b exp 1 0", timeout_p, busy); end
    ticks(1);
    checks++; if (timeout_p !== 1'b0) begin errors++; $display("FAIL tmo_width got %b exp 0", timeout_p); end
    ticks(150);
    checks++; if (n_tmo - t0 != 1) begin errors++; $display("FAIL tmo_count got %0d exp 1", n_tmo - t0); end
    scl_oe = 2'b11;
    ticks(8);
    sda_oe = 2'b11;
    ticks(8);
    tlimit = 16'd0;
    t0 = n_tmo;
    sda_oe = 2'b10;
    ticks(8);
    scl_oe = 2'b10;
    ticks(300);
    checks++; if (n_tmo != t0 || busy !== 1'b1)
      begin errors++; $display("FAIL tmo_disabled got pulses %0d busy %b exp 0 1", n_tmo - t0, busy); end
    scl_oe = 2'b11;
    ticks(8);
    sda_oe = 2'b11;
    ticks(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_disabled_stop got busy %b exp 0", busy); end
  endtask

  task automatic test_simultaneous_and_repeated;
    int s0, p0, busy_drop;
    s0 = n_start; p0 = n_stop;
    ext_scl = 1'b0; ext_sda = 1'b0;
    ticks(10);
    ext_scl = 1'b1; ext_sda = 1'b1;
    ticks(10);
    checks++; if (n_start != s0 || n_stop != p0 || busy !== 1'b0)
      begin errors++; $display("FAIL simul_edges got start %0d stop %0d busy %b exp 0 0 0", n_start - s0, n_stop - p0, busy); end
    sda_oe = 2'b10;
    ticks(8);
    scl_oe = 2'b10;
    ticks(6);
    sda_oe = 2'b11;
    ticks(6);
    scl_oe = 2'b11;
    ticks(8);
    s0 = n_start;
    busy_drop = 0;
    sda_oe = 2'b10;
    for (int i = 0; i < 10; i++) begin
      ticks(1);
      if (busy !== 1'b1) busy_drop++;
    end
    checks++; if (n_start - s0 != 1 || busy_drop != 0)
      begin errors++; $display("FAIL repeated_start got pulses %0d busy_drops %0d exp 1 0", n_start - s0, busy_drop); end
    checks++; if (arb_lost !== 2'b00) begin errors++; $display("FAIL repeated_start_arb got %b exp 00", arb_lost); end
    sda_oe = 2'b11;
    ticks(8);
  endtask

  task automatic test_reset_mid;
    int p0;
    sda_oe = 2'b01;
    ticks(8);
    scl_oe = 2'b10;
    ticks(8);
    checks++; if (busy !== 1'b1 || scl_f !== 1'b0)
      begin errors++; $display("FAIL mid_pre got busy %b scl_f %b exp 1 0", busy, scl_f); end
    p0 = n_stop;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || scl_f !== 1'b1 || sda_f !== 1'b1 || start_p !== 1'b0 || arb_lost !== 2'b00)
      begin errors++; $display("FAIL mid_reset got busy %b scl %b sda %b start %b arb %b exp 0 1 1 0 00", busy, scl_f, sda_f, start_p, arb_lost); end
    checks++; if (scl_pad_oe !== 1'b0 || sda_pad_oe !== 1'b0)
      begin errors++; $display("FAIL mid_reset_pad got scl %b sda %b exp 0 0", scl_pad_oe, sda_pad_oe); end
    ticks(2);
    scl_oe = 2'b11; sda_oe = 2'b11;
    ticks(2);
    rst_n = 1'b1;
    ticks(10);
    checks++; if (n_stop != p0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_no_stop got stops %0d busy %b exp 0 0", n_stop - p0, busy); end
  endtask

  initial begin
    test_reset;
    test_start_stop;
    test_glitch;
    test_arbitration;
    test_timeout;
    test_simultaneous_and_repeated;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
